// File: rtl/rng_wb_fetcher.sv
// Wishbone master that configures the RNG slave, polls its status and streams fetched words out.
// Optional ack watchdog enabled by defining RNG_FETCH_TIMEOUT_EN.
module rng_wb_fetcher #(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter logic [5:0]  CTRL_VALUE     = 6'b100011,
    parameter int unsigned BR_W           = 5,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        i_sysClock,
    input  logic        wb_rst_i,
    input  logic        i_start,
    input  logic [15:0] i_nWords,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic [31:0] o_word,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_POLL, S_DATA, S_PUSH, S_DONE, S_ERR
    } state_t;

    state_t      state;
    logic [15:0] count;

`ifdef RNG_FETCH_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
`endif

    always_ff @(posedge i_sysClock) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            count     <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            o_word    <= '0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
`ifdef RNG_FETCH_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        o_busy <= 1'b1;
                        o_err  <= 1'b0;
                        if (i_nWords == '0) begin
                            state <= S_DONE;
                        end else begin
                            count <= i_nWords;
                            state <= S_CFG;
                        end
                    end
                end
                // A bus state spends its first cycle idle (cyc low), which also
                // provides the mandatory gap after the previous transaction.
                S_CFG, S_POLL, S_DATA: begin
                    if (!wbm_cyc_o) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= (state == S_CFG);
                        wbm_dat_o <= (state == S_CFG) ? 32'(CTRL_VALUE) : '0;
                        case (state)
                            S_CFG:   wbm_adr_o <= BASE_ADDR;
                            S_POLL:  wbm_adr_o <= BASE_ADDR + 32'h08;
                            default: wbm_adr_o <= BASE_ADDR + 32'h10;
                        endcase
`ifdef RNG_FETCH_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                    end else if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        case (state)
                            S_CFG: state <= S_POLL;
                            S_POLL: begin
                                if (wbm_dat_i[BR_W-1:0] >= BR_W'(4))
                                    state <= S_DATA;
                            end
                            default: begin
                                o_word  <= wbm_dat_i;
                                o_valid <= 1'b1;
                                count   <= count - 16'd1;
                                state   <= S_PUSH;
                            end
                        endcase
                    end
`ifdef RNG_FETCH_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        o_err     <= 1'b1;
                        state     <= S_ERR;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                S_PUSH: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= (count == '0) ? S_DONE : S_POLL;
                    end
                end
                S_DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                S_ERR: begin
                    count  <= '0;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rng_wb_fetcher.md
# rng_wb_fetcher

Wishbone bus master that drives the RNG peripheral's slave port from the initiator side. On a start request it writes the RNG control register, polls the status register until at least one full word is buffered, reads the requested number of 32-bit words from the data window, and hands each one to a downstream consumer over a valid/ready stream. It sits between the RNG slave and any on-chip consumer (DMA, key loader, test harness) that needs bulk random words without firmware polling.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000, slave base; register offsets are added to it.
- CTRL_VALUE, 6'b100011, word written to control (offset 0x00): latches enable, aux enable, sys-clock mode.
- BR_W, 5, width of the bytes-ready field in status (offset 0x08, bits [BR_W-1:0]).
- TIMEOUT_CYCLES, 64, ack watchdog limit (only with RNG_FETCH_TIMEOUT_EN).

Ports (one clock; reset is synchronous and active-high):
- i_sysClock  in  1  clock for all logic.
- wb_rst_i  in  1  synchronous active-high reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_nWords  in  16  words to fetch; captured with i_start.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_we_o  out  1  1 = write.
- wbm_adr_o  out  32  byte address.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  slave acknowledge.
- o_word  out  32  fetched random word.
- o_valid  out  1  o_word valid.
- i_ready  in  1  consumer accepts o_word.
- o_busy  out  1  high outside IDLE.
- o_done  out  1  one-cycle pulse at job completion.
- o_err  out  1  sticky timeout flag; cleared by next accepted i_start.

## Operation
- States: IDLE, CFG, POLL, DATA, PUSH, DONE, ERR.
- IDLE: i_start=1 with i_nWords=0 -> DONE (no bus traffic). i_start=1, nonzero -> latch count, clear o_err, go CFG.
- CFG: write CTRL_VALUE (zero-extended) to BASE_ADDR+0x00, wbm_we_o=1. On ack -> POLL.
- POLL: read BASE_ADDR+0x08. On ack, if wbm_dat_i[BR_W-1:0] >= 4 -> DATA, else reissue POLL after the mandatory idle cycle.
- DATA: read BASE_ADDR+0x10. On ack, capture wbm_dat_i into o_word, decrement count -> PUSH.
- PUSH: o_valid=1 until i_ready. On handshake: count 0 -> DONE, else -> POLL.
- DONE: o_done=1 for one cycle -> IDLE.
- ERR: entered from any bus state on timeout; bus released, o_err=1 -> IDLE next cycle. Count discarded.
- i_start while busy ignored. i_nWords changes after capture have no effect.

## Timing
- Reset values: wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_adr_o=0, wbm_dat_o=0, o_word=0, o_valid=0, o_busy=0, o_done=0, o_err=0; state IDLE.
- All outputs registered. cyc and stb rise together the cycle after entering a bus state and stay constant (address, we, data) until ack.
- Ack sampled at posedge: cyc/stb drop on the following edge; at least one cycle with cyc=stb=0 between consecutive transactions (the slave's ack is registered and guards on its previous ack).
- Against a one-cycle-latency slave: each transaction = 3 cycles (stb, ack, idle). Minimum per word with consumer always ready: POLL 3 + DATA 3 + PUSH 1 = 7 cycles.
- o_word/o_valid update on the edge after data ack; o_valid drops the edge after i_ready=1 sampled.
- Reset mid-transaction: cyc/stb low on the next edge regardless of ack; pending o_valid dropped.
- Ack arriving while stb=0 ignored.

## Configuration
- RNG_FETCH_TIMEOUT_EN defined: counter increments each cycle stb=1 without ack; reaching TIMEOUT_CYCLES -> drop cyc/stb, enter ERR, o_err=1.
- Undefined: no counter; master waits for ack indefinitely; o_err tied 0; ERR state unreachable.

## Test plan
- Reset held 3 cycles mid-POLL -> all outputs 0, cyc/stb low one edge after reset.
- i_start, i_nWords=0 -> o_done pulse 2 cycles later, no cyc assertion.
- i_nWords=2, slave status 0x08 returns 8, data 0xDEADBEEF then 0x12345678, i_ready=1 -> write 0x23 to +0x00, then two POLL/DATA pairs, o_word sequence matches, o_done after second handshake.
- Status returns 0, 0, 4 -> exactly three POLL reads before first DATA read, idle cycle between each.
- i_ready held low 10 cycles in PUSH -> o_valid and o_word stable, no bus activity, resume on i_ready.
- With RNG_FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=64, slave never acks -> cyc/stb drop after 64 stb cycles, o_err=1, o_busy=0; next i_start clears o_err.
